ram_port_arbiter: RTL

//   Shares one dual-read / single-write RAM (1 write port, 2 synchronous read ports,
//   1-cycle read latency) between N_REQ requesters. Each cycle grants at most one

---
 rtl/ram_port_arbiter_pkg.sv | 20 ++
 rtl/ram_port_arbiter_if.sv | 41 ++++
 rtl/ram_port_arbiter_rr_arbiter.sv | 35 +++
 rtl/ram_port_arbiter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// Shared constants, response-route record and pointer helper for ram_port_arbiter.
package ram_arb_pkg;

    localparam int unsigned BW_DEF    = 32'd32;
    localparam int unsigned AW_DEF    = 32'd5;
    localparam int unsigned N_REQ_DEF = 32'd4;
    localparam int unsigned OWN_W     = 32'd3;

    typedef struct packed {
        logic             valid;
        logic [OWN_W-1:0] owner;
        logic             port_sel;
        logic             bypass;
    } rsp_route_t;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1) % n;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester, response and RAM-port signal bundle; the arbiter sits on the slave modport.
interface ram_arb_if
    import ram_arb_pkg::*;
#(
    parameter int unsigned BW    = BW_DEF,
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned N_REQ = N_REQ_DEF
) ();

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_write;
    logic [N_REQ*AW-1:0] req_addr;
    logic [N_REQ*BW-1:0] req_wdata;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ-1:0]    rsp_valid;
    logic [N_REQ*BW-1:0] rsp_rdata;
    logic                ram_write_en;
    logic [BW-1:0]       ram_data_in;
    logic [AW-1:0]       ram_addr_in;
    logic                ram_read_en1;
    logic [AW-1:0]       ram_addr_out_1;
    logic [BW-1:0]       ram_data_out1;
    logic                ram_read_en2;
    logic [AW-1:0]       ram_addr_out_2;
    logic [BW-1:0]       ram_data_out2;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, ram_data_out1, ram_data_out2,
        output req_ready, rsp_valid, rsp_rdata,
        output ram_write_en, ram_data_in, ram_addr_in,
        output ram_read_en1, ram_addr_out_1, ram_read_en2, ram_addr_out_2
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, ram_data_out1, ram_data_out2,
        input  req_ready, rsp_valid, rsp_rdata,
        input  ram_write_en, ram_data_in, ram_addr_in,
        input  ram_read_en1, ram_addr_out_1, ram_read_en2, ram_addr_out_2
    );

endinterface

// File: rtl/ram_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after i_ptr, wrapping.
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned N  = N_REQ_DEF,
    parameter int unsigned PW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);

    // Scan from the pointer and keep the first hit.
    always_comb begin
        int unsigned j;
        logic        found;
        o_grant = '0;
        o_idx   = '0;
        found   = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(i_ptr) + k) % N;
            if (!found && i_req[j]) begin
                o_grant[j] = 1'b1;
                o_idx      = PW'(j);
                found      = 1'b1;
            end else begin
                found = found;
            end
        end
        o_any = found;
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares a 1W/2R synchronous RAM between N_REQ requesters with round-robin grants.
// Define RAM_ARB_WR_BYPASS_EN to forward same-cycle write data to matching reads.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned BW    = BW_DEF,
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned N_REQ = N_REQ_DEF
) (
    input  logic     clk,
    input  logic     rst,
    ram_arb_if.slave bus
);

    localparam int unsigned PW = $clog2(N_REQ);

    logic [PW-1:0]       r_wr_ptr, r_rd_ptr;
    rsp_route_t          r_route [2];
    logic [N_REQ*BW-1:0] r_rsp_hold;

    logic [N_REQ-1:0]    w_wr_req, w_rd_req, w_rd_req2;
    logic [N_REQ-1:0]    w_wr_gnt, w_rd_gnt1, w_rd_gnt2;
    logic [PW-1:0]       w_wr_idx, w_rd_idx1, w_rd_idx2, w_rd_last;
    logic                w_wr_any, w_rd_any1, w_rd_any2;
    logic [AW-1:0]       w_wr_addr, w_rd_addr1, w_rd_addr2;
    logic [BW-1:0]       w_wr_data, w_byp_word;
    logic                w_byp1, w_byp2;
    logic [BW-1:0]       w_port_data [2];
    logic [N_REQ-1:0]    w_rsp_valid;
    logic [N_REQ*BW-1:0] w_rsp_rdata;

    assign w_wr_req  = rst ? '0 : (bus.req_valid & bus.req_write);
    assign w_rd_req  = rst ? '0 : (bus.req_valid & ~bus.req_write);
    assign w_rd_req2 = w_rd_req & ~w_rd_gnt1;

    rr_arbiter #(.N(N_REQ), .PW(PW)) u_wr_arb (
        .i_req(w_wr_req), .i_ptr(r_wr_ptr), .o_grant(w_wr_gnt), .o_idx(w_wr_idx), .o_any(w_wr_any)
    );
    rr_arbiter #(.N(N_REQ), .PW(PW)) u_rd_arb1 (
        .i_req(w_rd_req), .i_ptr(r_rd_ptr), .o_grant(w_rd_gnt1), .o_idx(w_rd_idx1), .o_any(w_rd_any1)
    );
    // Second read port: same scan with the first winner removed.
    rr_arbiter #(.N(N_REQ), .PW(PW)) u_rd_arb2 (
        .i_req(w_rd_req2), .i_ptr(r_rd_ptr), .o_grant(w_rd_gnt2), .o_idx(w_rd_idx2), .o_any(w_rd_any2)
    );

    assign w_wr_addr  = bus.req_addr[w_wr_idx*AW +: AW];
    assign w_wr_data  = bus.req_wdata[w_wr_idx*BW +: BW];
    assign w_rd_addr1 = bus.req_addr[w_rd_idx1*AW +: AW];
    assign w_rd_addr2 = bus.req_addr[w_rd_idx2*AW +: AW];
    assign w_rd_last  = w_rd_any2 ? w_rd_idx2 : w_rd_idx1;

    assign bus.req_ready      = w_wr_gnt | w_rd_gnt1 | w_rd_gnt2;
    assign bus.ram_write_en   = w_wr_any;
    assign bus.ram_addr_in    = w_wr_any ? w_wr_addr : '0;
    assign bus.ram_data_in    = w_wr_any ? w_wr_data : '0;
    assign bus.ram_read_en1   = w_rd_any1;
    assign bus.ram_addr_out_1 = w_rd_any1 ? w_rd_addr1 : '0;
    assign bus.ram_read_en2   = w_rd_any2;
    assign bus.ram_addr_out_2 = w_rd_any2 ? w_rd_addr2 : '0;

`ifdef RAM_ARB_WR_BYPASS_EN
    logic [BW-1:0] r_byp_data;

    assign w_byp1     = w_wr_any & w_rd_any1 & (w_wr_addr == w_rd_addr1);
    assign w_byp2     = w_wr_any & w_rd_any2 & (w_wr_addr == w_rd_addr2);
    assign w_byp_word = r_byp_data;

    // Capture granted write data for reads that hit the same address.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_byp_data <= '0;
        end else if (w_wr_any) begin
            r_byp_data <= w_wr_data;
        end else begin
            r_byp_data <= r_byp_data;
        end
    end
`else
    assign w_byp1     = 1'b0;
    assign w_byp2     = 1'b0;
    assign w_byp_word = '0;
`endif

    // Pick the data source for each read port's response.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            if (r_route[p].bypass) begin
                w_port_data[p] = w_byp_word;
            end else if (r_route[p].port_sel) begin
                w_port_data[p] = bus.ram_data_out2;
            end else begin
                w_port_data[p] = bus.ram_data_out1;
            end
        end
    end

    // Steer port data to its owner; idle slices show the last delivered value.
    always_comb begin
        w_rsp_valid = '0;
        w_rsp_rdata = r_rsp_hold;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!rst && r_route[p].valid && (r_route[p].owner == OWN_W'(i))) begin
                    w_rsp_valid[i]          = 1'b1;
                    w_rsp_rdata[i*BW +: BW] = w_port_data[p];
                end else begin
                    w_rsp_valid[i] = w_rsp_valid[i];
                end
            end
        end
    end

    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_rdata = w_rsp_rdata;

    // Pointers, response routes and held read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_route[0] <= '0;
            r_route[1] <= '0;
            r_rsp_hold <= '0;
        end else begin
            if (w_wr_any) begin
                r_wr_ptr <= PW'(rr_next(32'(w_wr_idx), N_REQ));
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_rd_any1) begin
                r_rd_ptr <= PW'(rr_next(32'(w_rd_last), N_REQ));
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            r_route[0] <= '{w_rd_any1, OWN_W'(w_rd_idx1), 1'b0, w_byp1};
            r_route[1] <= '{w_rd_any2, OWN_W'(w_rd_idx2), 1'b1, w_byp2};
            r_rsp_hold <= w_rsp_rdata;
        end
    end

endmodule
